phy_link_ctrl: RTL and testbench
================================

# phy_link_ctrl

- Sequences the 32-bit, 75 MHz side of the device PHY interface.
- Brings the link up by transmitting ALIGN until the partner's ALIGNs are seen, then drives `link_up`.
- Once up, it shares the TX dword slot between the link layer and mandatory ALIGN-pair insertion, stalling the link layer during inserted ALIGNs.
- It sits between the link layer and the 16/32-bit PHY width converter, whose TX FIFO consumes one dword every `clk` cycle.

## Interface
- `ALIGN_PERIOD`, 256: link-layer dwords sent between consecutive ALIGN pairs; legal range ≥4.
- `ALIGN_LOCK_CNT`, 3: consecutive received ALIGN dwords required to declare link up; legal range ≥1.
- `ALIGN_TIMEOUT`, 32768: `clk` cycles in ALIGN_TX without lock before `link_fail` pulses.
- `clk` in 1: 75 MHz dword clock.
- `host_rst` in 1: asynchronous, active-high reset.
- `phy_ready` in 1: OOB complete / PHY usable; level.
- `rx_data` in 32: received dword from the PHY interface.
- `rx_k` in 1: K flag for byte 0 of `rx_data`.
- `lnk_tx_data` in 32: link-layer TX dword.
- `lnk_tx_k` in 1: link-layer K flag for byte 0.
- `lnk_tx_ack` out 1: `lnk_tx_data`/`lnk_tx_k` are consumed at this rising edge.
- `dev_tx_data` out 32: dword to the PHY interface TX FIFO.
- `tx_k` out 1: K flag for byte 0 of `dev_tx_data`.
- `link_up` out 1: link established; level.
- `link_fail` out 1: one-cycle pulse on lock timeout.

## Operation
- ALIGN is 32'h7B4A4ABC with K set; it is recognised only when `rx_k`=1 and `rx_data`=ALIGN.
- FSM states: WAIT_PHY, ALIGN_TX, DATA, INS_ALIGN.
- WAIT_PHY
  - TX: ALIGN. Counters held at 0.
  - `phy_ready`=1 → ALIGN_TX.
- ALIGN_TX
  - TX: ALIGN continuously.
  - Lock counter: +1 per received ALIGN, cleared by any other dword, saturates at `ALIGN_LOCK_CNT`.
  - Lock counter reaching `ALIGN_LOCK_CNT` → DATA.
  - Timeout counter: +1 per cycle. Reaching `ALIGN_TIMEOUT`-1 pulses `link_fail`, clears both counters and stays in ALIGN_TX.
  - Lock and timeout on the same edge: lock wins, no `link_fail`.
- DATA
  - `link_up`=1, `lnk_tx_ack`=1.
  - TX: `lnk_tx_data`/`lnk_tx_k` registered.
  - Period counter: +1 per cycle. At `ALIGN_PERIOD`-1 it wraps to 0 and → INS_ALIGN.
- INS_ALIGN
  - `link_up`=1, `lnk_tx_ack`=0. TX: ALIGN for exactly 2 cycles, then → DATA.
  - Received dwords are ignored.
- From any state other than WAIT_PHY, `phy_ready`=0 → WAIT_PHY at the next edge. `link_up` drops and TX returns to ALIGN, including mid-pair; counters clear.
- `lnk_tx_ack` is combinational from state (1 only in DATA). The link layer must hold its dword while `lnk_tx_ack`=0.

## Timing
- Reset values: `dev_tx_data`=32'h7B4A4ABC, `tx_k`=1, `link_up`=0, `lnk_tx_ack`=0, `link_fail`=0, state WAIT_PHY, all counters 0.
- TX latency: a dword acked at edge N appears on `dev_tx_data` after edge N.
- Lock timing: the N-th consecutive ALIGN is sampled at edge E; `link_up`=1 and `lnk_tx_ack`=1 follow edge E.
- Steady-state TX pattern: `ALIGN_PERIOD` link dwords, then 2 ALIGN, repeating. No dword is dropped or duplicated.
- `link_fail` is registered and high for exactly 1 cycle.
- `phy_ready` is assumed to be already synchronous to `clk`.

## Structure
- Shared package `sata_prim_pkg`: ALIGN constant 32'h7B4A4ABC, SYNC constant 32'hB5B5957C, FSM state enum.
- Single module, no sub-module.
- Counter widths are `$clog2` of their respective parameters.

## Test plan
- Reset: assert `host_rst` asynchronously mid-cycle → all outputs take their reset values immediately, with no clock edge required.
- Lock filter, `ALIGN_LOCK_CNT`=3: rx sequence ALIGN, ALIGN, SYNC, ALIGN, ALIGN, ALIGN → `link_up` rises one cycle after the 6th dword, not after the 2nd.
- Insertion, `ALIGN_PERIOD`=8, counting link data 0..N →
  - TX carries data 0–7, ALIGN, ALIGN, data 8–15, ALIGN, ALIGN.
  - `lnk_tx_ack` is low exactly during the ALIGN slots.
  - No data value is skipped or repeated.
- Timeout, `ALIGN_TIMEOUT`=16, no rx ALIGN → `link_fail` pulses every 16 cycles; `link_up` stays 0.
- Drop during insertion: `phy_ready`=0 during the first INS_ALIGN cycle → next edge gives state WAIT_PHY, `link_up`=0, `lnk_tx_ack`=0.
- Recovery: after the drop, re-assert `phy_ready` and send 3 ALIGN → the period counter restarts from 0, and 8 full data dwords precede the first ALIGN pair.

Source files
------------

// File: rtl/sata_prim_pkg.sv
// Shared SATA primitive encodings and the PHY link sequencer state type.
package sata_prim_pkg;

  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNC_PRIM  = 32'hB5B5_957C;

  typedef enum logic [1:0] {
    ST_WAIT_PHY  = 2'd0,
    ST_ALIGN_TX  = 2'd1,
    ST_DATA      = 2'd2,
    ST_INS_ALIGN = 2'd3
  } link_state_e;

endpackage

// File: rtl/phy_link_ctrl.sv
// Dword-side PHY link sequencer: ALIGN handshake to bring the link up, then
// periodic ALIGN-pair insertion into the link-layer TX stream.
module phy_link_ctrl
  import sata_prim_pkg::*;
#(
  parameter int unsigned ALIGN_PERIOD   = 256,
  parameter int unsigned ALIGN_LOCK_CNT = 3,
  parameter int unsigned ALIGN_TIMEOUT  = 32768
) (
  input  logic        clk,
  input  logic        host_rst,
  input  logic        phy_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_k,
  input  logic [31:0] lnk_tx_data,
  input  logic        lnk_tx_k,
  output logic        lnk_tx_ack,
  output logic [31:0] dev_tx_data,
  output logic        tx_k,
  output logic        link_up,
  output logic        link_fail
);

  localparam int unsigned PW = $clog2(ALIGN_PERIOD);
  // Lock counter must be able to represent ALIGN_LOCK_CNT itself.
  localparam int unsigned LW = $clog2(ALIGN_LOCK_CNT + 1);
  localparam int unsigned TW = $clog2(ALIGN_TIMEOUT);

  link_state_e state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ins_q, ins_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic          tx_k_q, tx_k_d;
  logic          link_up_q, link_up_d;
  logic          link_fail_q, link_fail_d;
  logic          rx_align;
  logic          locked;

  always_ff @(posedge clk or posedge host_rst) begin
    if (host_rst) begin
      state_q     <= ST_WAIT_PHY;
      period_q    <= '0;
      lock_q      <= '0;
      tmo_q       <= '0;
      ins_q       <= 1'b0;
      tx_data_q   <= ALIGN_PRIM;
      tx_k_q      <= 1'b1;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      lock_q      <= lock_d;
      tmo_q       <= tmo_d;
      ins_q       <= ins_d;
      tx_data_q   <= tx_data_d;
      tx_k_q      <= tx_k_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    lock_d      = lock_q;
    tmo_d       = tmo_q;
    ins_d       = ins_q;
    tx_data_d   = ALIGN_PRIM;
    tx_k_d      = 1'b1;
    link_fail_d = 1'b0;
    rx_align    = rx_k && (rx_data == ALIGN_PRIM);
    locked      = rx_align && (lock_q == LW'(ALIGN_LOCK_CNT - 1));

    case (state_q)
      ST_WAIT_PHY: begin
        period_d = '0;
        lock_d   = '0;
        tmo_d    = '0;
        ins_d    = 1'b0;
        if (phy_ready) state_d = ST_ALIGN_TX;
      end
      ST_ALIGN_TX: begin
        lock_d = rx_align ? lock_q + LW'(1) : '0;
        tmo_d  = tmo_q + TW'(1);
        // Lock takes priority over a coincident timeout.
        if (locked) begin
          state_d = ST_DATA;
          lock_d  = '0;
          tmo_d   = '0;
        end else if (tmo_q == TW'(ALIGN_TIMEOUT - 1)) begin
          link_fail_d = 1'b1;
          lock_d      = '0;
          tmo_d       = '0;
        end
      end
      ST_DATA: begin
        tx_data_d = lnk_tx_data;
        tx_k_d    = lnk_tx_k;
        if (period_q == PW'(ALIGN_PERIOD - 1)) begin
          period_d = '0;
          ins_d    = 1'b0;
          state_d  = ST_INS_ALIGN;
        end else begin
          period_d = period_q + PW'(1);
        end
      end
      ST_INS_ALIGN: begin
        ins_d = 1'b1;
        if (ins_q) begin
          ins_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_WAIT_PHY;
    endcase

    // Losing the PHY overrides everything, including a pending lock or pair.
    if (!phy_ready && (state_q != ST_WAIT_PHY)) begin
      state_d     = ST_WAIT_PHY;
      period_d    = '0;
      lock_d      = '0;
      tmo_d       = '0;
      ins_d       = 1'b0;
      tx_data_d   = ALIGN_PRIM;
      tx_k_d      = 1'b1;
      link_fail_d = 1'b0;
    end

    link_up_d = (state_d == ST_DATA) || (state_d == ST_INS_ALIGN);
  end

  assign lnk_tx_ack  = (state_q == ST_DATA);
  assign dev_tx_data = tx_data_q;
  assign tx_k        = tx_k_q;
  assign link_up     = link_up_q;
  assign link_fail   = link_fail_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl: lock filter, ALIGN insertion, PHY drop,
// recovery, asynchronous reset and lock timeout.
module tb_phy_link_ctrl;
  import sata_prim_pkg::*;

  logic        clk;
  logic        host_rst;
  logic        phy_ready;
  logic [31:0] rx_data;
  logic        rx_k;
  logic [31:0] lnk_tx_data;
  logic        lnk_tx_k;
  logic        lnk_tx_ack;
  logic [31:0] dev_tx_data;
  logic        tx_k;
  logic        link_up;
  logic        link_fail;

  int n_checks = 0;
  int n_fail   = 0;

  phy_link_ctrl #(
    .ALIGN_PERIOD  (8),
    .ALIGN_LOCK_CNT(3),
    .ALIGN_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .host_rst   (host_rst),
    .phy_ready  (phy_ready),
    .rx_data    (rx_data),
    .rx_k       (rx_k),
    .lnk_tx_data(lnk_tx_data),
    .lnk_tx_k   (lnk_tx_k),
    .lnk_tx_ack (lnk_tx_ack),
    .dev_tx_data(dev_tx_data),
    .tx_k       (tx_k),
    .link_up    (link_up),
    .link_fail  (link_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".tx_data"}, dev_tx_data, ALIGN_PRIM);
    chk({tag, ".tx_k"}, 32'(tx_k), 32'd1);
    chk({tag, ".link_up"}, 32'(link_up), 32'd0);
    chk({tag, ".ack"}, 32'(lnk_tx_ack), 32'd0);
    chk({tag, ".link_fail"}, 32'(link_fail), 32'd0);
  endtask

  // Link layer presents base+idx, advancing only on ack. Expected TX stream:
  // 8 link dwords then 2 ALIGNs, repeating from the first DATA cycle.
  task automatic run_stream(input int n, input logic [31:0] base, input string tag);
    int idx = 0;
    logic ack_seen;
    int p;
    logic [31:0] exp_d;
    for (int c = 0; c < n; c++) begin
      p = c % 10;
      lnk_tx_data = base + 32'(idx);
      lnk_tx_k    = 1'b0;
      ack_seen    = lnk_tx_ack;
      chk($sformatf("%s.ack[%0d]", tag, c), 32'(lnk_tx_ack), 32'(p < 8));
      tick();
      if (ack_seen) idx++;
      exp_d = (p < 8) ? base + 32'((c / 10) * 8 + p) : ALIGN_PRIM;
      chk($sformatf("%s.tx[%0d]", tag, c), dev_tx_data, exp_d);
      chk($sformatf("%s.txk[%0d]", tag, c), 32'(tx_k), 32'(p >= 8));
      chk($sformatf("%s.up[%0d]", tag, c), 32'(link_up), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] lock_seq [6];
    lock_seq[0] = ALIGN_PRIM; lock_seq[1] = ALIGN_PRIM; lock_seq[2] = SYNC_PRIM;
    lock_seq[3] = ALIGN_PRIM; lock_seq[4] = ALIGN_PRIM; lock_seq[5] = ALIGN_PRIM;

    host_rst    = 1'b1;
    phy_ready   = 1'b0;
    rx_data     = SYNC_PRIM;
    rx_k        = 1'b1;
    lnk_tx_data = 32'h0;
    lnk_tx_k    = 1'b0;
    #2;
    chk_idle_outputs("reset");
    tick();
    tick();
    host_rst = 1'b0;
    tick();
    chk_idle_outputs("wait_phy");

    // Lock filter: a SYNC in the middle restarts the count.
    phy_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      rx_data = lock_seq[i];
      tick();
      chk($sformatf("lock.up[%0d]", i), 32'(link_up), 32'(i == 5));
      chk($sformatf("lock.ack[%0d]", i), 32'(lnk_tx_ack), 32'(i == 5));
      chk($sformatf("lock.tx[%0d]", i), dev_tx_data, ALIGN_PRIM);
    end
    rx_data = SYNC_PRIM;

    // Two full periods plus the next 8 dwords; ends in the first INS_ALIGN cycle.
    run_stream(28, 32'h1000_0000, "ins");
    chk("ins_entry.ack", 32'(lnk_tx_ack), 32'd0);
    chk("ins_entry.state", 32'(dut.state_q), 32'(ST_INS_ALIGN));

    // Drop PHY in the middle of the ALIGN pair.
    phy_ready = 1'b0;
    tick();
    chk("drop.state", 32'(dut.state_q), 32'(ST_WAIT_PHY));
    chk_idle_outputs("drop");

    // Recovery: period restarts from zero, 8 dwords before the first pair.
    phy_ready = 1'b1;
    tick();
    rx_data = ALIGN_PRIM;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("relock.up[%0d]", i), 32'(link_up), 32'(i == 2));
    end
    rx_data = SYNC_PRIM;
    run_stream(12, 32'h2000_0000, "recov");

    // Asynchronous reset mid-cycle while carrying link data.
    chk("pre_rst.tx", dev_tx_data, 32'h2000_0009);
    #3;
    host_rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst.state", 32'(dut.state_q), 32'(ST_WAIT_PHY));
    tick();
    host_rst = 1'b0;

    // Timeout: no ALIGN received, link_fail every 16 cycles.
    tick();
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk($sformatf("tmo.fail[%0d]", k), 32'(link_fail), 32'((k % 16) == 0));
      chk($sformatf("tmo.up[%0d]", k), 32'(link_up), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
